// File: rtl/ysyx_22050710_lsu_pkg.sv
// Shared types and helpers for the LSU controller and its lane-alignment datapath.
package ysyx_22050710_lsu_pkg;

  typedef enum logic [2:0] {
    MEMOP_LB   = 3'b000,
    MEMOP_LBU  = 3'b001,
    MEMOP_LH   = 3'b010,
    MEMOP_LHU  = 3'b011,
    MEMOP_LW   = 3'b100,
    MEMOP_LWU  = 3'b101,
    MEMOP_LD   = 3'b110,
    MEMOP_NONE = 3'b111
  } memop_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  // Access size as log2(bytes): the upper two opcode bits encode it directly.
  function automatic logic [1:0] memop_size(memop_e op);
    return op[2:1];
  endfunction

  function automatic logic memop_signed(memop_e op);
    return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW);
  endfunction

  function automatic logic [2:0] memop_align_mask(memop_e op);
    case (op[2:1])
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Combinational byte-lane steering: store strobes/data shifted to the lane offset,
// load data shifted down, truncated to access size and sign/zero-extended.
import ysyx_22050710_lsu_pkg::*;

module ysyx_22050710_lsu_align #(
  parameter int XLEN  = 64,
  parameter int BUS_W = 64,
  parameter int LO_W  = $clog2(BUS_W / 8)
) (
  input  logic [LO_W-1:0]    offset,
  input  logic [2:0]         mem_op,
  input  logic [XLEN-1:0]    wdata,
  input  logic [BUS_W-1:0]   rdata,
  output logic [BUS_W/8-1:0] wmask,
  output logic [BUS_W-1:0]   wdata_bus,
  output logic [XLEN-1:0]    rdata_ext
);

  logic [1:0]         size_log2;
  logic               sign_en;
  logic [BUS_W/8-1:0] base_mask;
  logic [BUS_W-1:0]   shifted;
  logic [63:0]        word;
  logic [63:0]        ext;

  always_comb begin
    size_log2 = memop_size(memop_e'(mem_op));
    sign_en   = memop_signed(memop_e'(mem_op));
    base_mask = '0;
    for (int i = 0; i < BUS_W / 8; i++) begin
      base_mask[i] = (i < (1 << size_log2));
    end
    wmask     = base_mask << offset;
    wdata_bus = BUS_W'(wdata) << {offset, 3'b000};
    shifted   = rdata >> {offset, 3'b000};
    word      = 64'(shifted);
    // ld needs no extension; with XLEN=32 it never reaches here as a trapped access.
    case (size_log2)
      2'd0:    ext = {{56{sign_en & word[7]}},  word[7:0]};
      2'd1:    ext = {{48{sign_en & word[15]}}, word[15:0]};
      2'd2:    ext = {{32{sign_en & word[31]}}, word[31:0]};
      default: ext = word;
    endcase
    rdata_ext = ext[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_22050710_lsu_ctrl.sv
// Handshaked load/store unit with one outstanding access and a bounded wait.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
import ysyx_22050710_lsu_pkg::*;

module ysyx_22050710_lsu_ctrl #(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int BUS_W       = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [XLEN-1:0]    i_wdata,
  input  logic [2:0]         i_MemOP,
  input  logic               i_WrEn,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [XLEN-1:0]    o_rdata,
  output logic               o_err,
  output logic               o_mem_req_valid,
  input  logic               i_mem_req_ready,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_we,
  output logic [BUS_W-1:0]   o_mem_wdata,
  output logic [BUS_W/8-1:0] o_mem_wmask,
  input  logic               i_mem_rsp_valid,
  input  logic [BUS_W-1:0]   i_mem_rdata,
  input  logic               i_mem_err
);

  localparam int LO_W  = $clog2(BUS_W / 8);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               timeout;
  memop_e             req_op;
  memop_e             lat_op;
  logic               lat_we;
  logic [LO_W-1:0]    lat_lo;
  logic [2:0]         align_mask;
  logic [ADDR_W-1:0]  addr_aligned;
  logic [LO_W-1:0]    cur_lo;
  logic [2:0]         cur_op;
  logic [BUS_W/8-1:0] al_wmask;
  logic [BUS_W-1:0]   al_wdata;
  logic [XLEN-1:0]    al_rdata;

  assign req_op       = memop_e'(i_MemOP);
  assign align_mask   = memop_align_mask(req_op);
  assign addr_aligned = i_addr & ~ADDR_W'(align_mask);
  assign cnt_nxt      = cnt + CNT_W'(1);
  assign timeout      = (cnt_nxt == CNT_W'(TIMEOUT_CYC));

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (|(i_addr[2:0] & align_mask)) ||
                    ((XLEN == 32) && (memop_size(req_op) == 2'd3));
`endif

  // One steering unit serves both directions: request fields in IDLE, latched ones afterwards.
  assign cur_lo = (state == S_IDLE) ? addr_aligned[LO_W-1:0] : lat_lo;
  assign cur_op = (state == S_IDLE) ? i_MemOP : lat_op;

  ysyx_22050710_lsu_align #(
    .XLEN  (XLEN),
    .BUS_W (BUS_W),
    .LO_W  (LO_W)
  ) u_align (
    .offset    (cur_lo),
    .mem_op    (cur_op),
    .wdata     (i_wdata),
    .rdata     (i_mem_rdata),
    .wmask     (al_wmask),
    .wdata_bus (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      lat_op          <= MEMOP_LB;
      lat_we          <= 1'b0;
      lat_lo          <= '0;
      o_req_ready     <= 1'b1;
      o_rsp_valid     <= 1'b0;
      o_rdata         <= '0;
      o_err           <= 1'b0;
      o_mem_req_valid <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_we        <= 1'b0;
      o_mem_wdata     <= '0;
      o_mem_wmask     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            lat_op      <= req_op;
            lat_we      <= i_WrEn;
            lat_lo      <= addr_aligned[LO_W-1:0];
            cnt         <= '0;
            o_req_ready <= 1'b0;
            if (req_op == MEMOP_NONE) begin
              state       <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rdata     <= '0;
              o_err       <= 1'b0;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            else if (misalign) begin
              state       <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rdata     <= '0;
              o_err       <= 1'b1;
            end
`endif
            else begin
              state           <= S_REQ;
              o_mem_req_valid <= 1'b1;
              o_mem_addr      <= {addr_aligned[ADDR_W-1:LO_W], {LO_W{1'b0}}};
              o_mem_we        <= i_WrEn;
              o_mem_wdata     <= al_wdata;
              o_mem_wmask     <= al_wmask;
            end
          end
        end

        // Timeout wins over a same-cycle handshake so the counter never passes its limit.
        S_REQ: begin
          if (timeout) begin
            state           <= S_RESP;
            o_mem_req_valid <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rdata         <= '0;
            o_err           <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
            if (i_mem_req_ready) begin
              state           <= S_WAIT;
              o_mem_req_valid <= 1'b0;
            end
          end
        end

        S_WAIT: begin
          if (i_mem_rsp_valid) begin
            state       <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_err       <= i_mem_err;
            o_rdata     <= (lat_we || i_mem_err) ? '0 : al_rdata;
          end else if (timeout) begin
            state       <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_rdata     <= '0;
            o_err       <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            state       <= S_IDLE;
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_lsu_ctrl.sv
// Directed bench for the LSU controller: one task per scenario, zero-wait and stalled memory,
// timeout (TIMEOUT_CYC=8), mid-access reset and back-pressure.
module tb_ysyx_22050710_lsu_ctrl;

  localparam int XLEN = 64;
  localparam int ADDR_W = 64;
  localparam int BUS_W = 64;
  localparam int TIMEOUT_CYC = 8;
  localparam logic [2:0] OP_LB = 3'b000, OP_LBU = 3'b001, OP_LH = 3'b010, OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW = 3'b100, OP_LWU = 3'b101, OP_LD = 3'b110, OP_NONE = 3'b111;
  localparam logic [63:0] WORD = 64'h1122_3344_8055_6677;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [ADDR_W-1:0]  addr = '0;
  logic [XLEN-1:0]    wdata = '0;
  logic [2:0]         mem_op = OP_NONE;
  logic               wr_en = 1'b0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [XLEN-1:0]    rdata;
  logic               err;
  logic               mem_req_valid;
  logic               mem_req_ready = 1'b1;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [BUS_W-1:0]   mem_wdata;
  logic [BUS_W/8-1:0] mem_wmask;
  logic               mem_rsp_valid = 1'b0;
  logic [BUS_W-1:0]   mem_rdata = '0;
  logic               mem_err = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ysyx_22050710_lsu_ctrl #(
    .XLEN        (XLEN),
    .ADDR_W      (ADDR_W),
    .BUS_W       (BUS_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_addr          (addr),
    .i_wdata         (wdata),
    .i_MemOP         (mem_op),
    .i_WrEn          (wr_en),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rdata         (rdata),
    .o_err           (err),
    .o_mem_req_valid (mem_req_valid),
    .i_mem_req_ready (mem_req_ready),
    .o_mem_addr      (mem_addr),
    .o_mem_we        (mem_we),
    .o_mem_wdata     (mem_wdata),
    .o_mem_wmask     (mem_wmask),
    .i_mem_rsp_valid (mem_rsp_valid),
    .i_mem_rdata     (mem_rdata),
    .i_mem_err       (mem_err)
  );

  // Stepping helpers only; every comparison lives in the scenario tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [63:0] a, input logic [63:0] d, input logic [2:0] op, input logic we);
    req_valid = 1'b1;
    addr = a;
    wdata = d;
    mem_op = op;
    wr_en = we;
  endtask

  task automatic send_req(input logic [63:0] a, input logic [63:0] d, input logic [2:0] op, input logic we);
    set_req(a, d, op, we);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic mem_respond(input logic [63:0] word, input logic e);
    mem_rsp_valid = 1'b1;
    mem_rdata = word;
    mem_err = e;
    tick();
    mem_rsp_valid = 1'b0;
    mem_err = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    else passes++;
    checks++;
    if ({rsp_valid, err, mem_req_valid, mem_we, rdata, mem_addr, mem_wdata, mem_wmask} !== '0)
      $display("FAIL reset_outputs: got rsp_valid=%b err=%b mem_req_valid=%b we=%b rdata=%h addr=%h wdata=%h wmask=%h expected all 0",
               rsp_valid, err, mem_req_valid, mem_we, rdata, mem_addr, mem_wdata, mem_wmask);
    else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_byte();
    send_req(64'h8000_0003, 64'h0, OP_LB, 1'b0);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_we !== 1'b0)
      $display("FAIL lb_request: got valid=%b addr=%h we=%b expected 1 80000000 0", mem_req_valid, mem_addr, mem_we);
    else passes++;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL lb_busy: got req_ready=%b rsp_valid=%b expected 0 0", req_ready, rsp_valid);
    else passes++;
    tick();
    checks++;
    if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL lb_wait: got mem_req_valid=%b rsp_valid=%b expected 0 0", mem_req_valid, rsp_valid);
    else passes++;
    mem_respond(WORD, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'hFFFF_FFFF_FFFF_FF80 || err !== 1'b0)
      $display("FAIL lb_response: got valid=%b rdata=%h err=%b expected 1 ffffffffffffff80 0", rsp_valid, rdata, err);
    else passes++;
    take_rsp();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL lb_release: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
    else passes++;
  endtask

  task automatic test_store_half();
    send_req(64'h8000_0006, 64'hABCD, OP_LH, 1'b1);
    checks++;
    if (mem_wmask !== 8'b1100_0000 || mem_wdata !== 64'hABCD_0000_0000_0000 || mem_we !== 1'b1 || mem_addr !== 64'h8000_0000)
      $display("FAIL sh_request: got wmask=%b wdata=%h we=%b addr=%h expected 11000000 abcd000000000000 1 80000000",
               mem_wmask, mem_wdata, mem_we, mem_addr);
    else passes++;
    tick();
    mem_respond(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'h0 || err !== 1'b0)
      $display("FAIL sh_response: got valid=%b rdata=%h err=%b expected 1 0 0", rsp_valid, rdata, err);
    else passes++;
    take_rsp();
  endtask

  task automatic test_misalign();
    send_req(64'h8000_0002, 64'h0, OP_LW, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || err !== 1'b1 || rdata !== 64'h0 || mem_req_valid !== 1'b0)
        $display("FAIL misalign_trap: got valid=%b err=%b rdata=%h mem_req_valid=%b expected 1 1 0 0",
                 rsp_valid, err, rdata, mem_req_valid);
      else passes++;
      tick();
    end
    take_rsp();
    checks++;
    if (mem_req_valid !== 1'b0) $display("FAIL misalign_no_mem: got %b expected 0", mem_req_valid);
    else passes++;
`else
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_wmask !== 8'h0F)
      $display("FAIL misalign_request: got valid=%b addr=%h wmask=%h expected 1 80000000 0f", mem_req_valid, mem_addr, mem_wmask);
    else passes++;
    tick();
    mem_respond(WORD, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'hFFFF_FFFF_8055_6677 || err !== 1'b0)
      $display("FAIL misalign_response: got valid=%b rdata=%h err=%b expected 1 ffffffff80556677 0", rsp_valid, rdata, err);
    else passes++;
    take_rsp();
`endif
  endtask

  task automatic test_load_extend();
    logic [2:0]  offs [8];
    logic [2:0]  ops  [8];
    logic [63:0] exps [8];
    offs = '{3'd3, 3'd2, 3'd2, 3'd4, 3'd0, 3'd0, 3'd7, 3'd6};
    ops  = '{OP_LBU, OP_LH, OP_LHU, OP_LWU, OP_LW, OP_LD, OP_LB, OP_LH};
    exps = '{64'h80, 64'hFFFF_FFFF_FFFF_8055, 64'h8055, 64'h1122_3344,
             64'hFFFF_FFFF_8055_6677, WORD, 64'h11, 64'h1122};
    for (int i = 0; i < 8; i++) begin
      send_req(64'h8000_0000 + 64'(offs[i]), 64'h0, ops[i], 1'b0);
      tick();
      mem_respond(WORD, 1'b0);
      checks++;
      if (rsp_valid !== 1'b1 || rdata !== exps[i] || err !== 1'b0)
        $display("FAIL load_ext_%0d: got valid=%b rdata=%h err=%b expected 1 %h 0", i, rsp_valid, rdata, err, exps[i]);
      else passes++;
      take_rsp();
    end
  endtask

  task automatic test_none_and_bus_err();
    send_req(64'h8000_0000, 64'h55, OP_NONE, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'h0 || err !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL none_op: got valid=%b rdata=%h err=%b mem_req_valid=%b expected 1 0 0 0", rsp_valid, rdata, err, mem_req_valid);
    else passes++;
    take_rsp();
    send_req(64'h8000_0008, 64'h0, OP_LD, 1'b0);
    tick();
    mem_respond(WORD, 1'b1);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'h0 || err !== 1'b1)
      $display("FAIL bus_err: got valid=%b rdata=%h err=%b expected 1 0 1", rsp_valid, rdata, err);
    else passes++;
    take_rsp();
  endtask

  task automatic test_timeout();
    int n;
    send_req(64'h8000_0010, 64'h0, OP_LD, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != TIMEOUT_CYC) $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TIMEOUT_CYC);
    else passes++;
    checks++;
    if (err !== 1'b1 || rdata !== 64'h0) $display("FAIL timeout_resp: got err=%b rdata=%h expected 1 0", err, rdata);
    else passes++;
    take_rsp();
    mem_respond(WORD, 1'b1);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL timeout_late_rsp: got rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
    else passes++;
    send_req(64'h8000_0003, 64'h0, OP_LB, 1'b0);
    tick();
    mem_respond(WORD, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'hFFFF_FFFF_FFFF_FF80 || err !== 1'b0)
      $display("FAIL timeout_recover: got valid=%b rdata=%h err=%b expected 1 ffffffffffffff80 0", rsp_valid, rdata, err);
    else passes++;
    take_rsp();
  endtask

  task automatic test_reset_in_wait();
    send_req(64'h8000_0000, 64'h0, OP_LD, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL rst_wait_state: got req_ready=%b rsp_valid=%b mem_req_valid=%b expected 1 0 0", req_ready, rsp_valid, mem_req_valid);
    else passes++;
    mem_respond(WORD, 1'b0);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rst_wait_stale: got rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
    else passes++;
    send_req(64'h8000_0002, 64'h0, OP_LHU, 1'b0);
    tick();
    mem_respond(WORD, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'h8055 || err !== 1'b0)
      $display("FAIL rst_wait_recover: got valid=%b rdata=%h err=%b expected 1 8055 0", rsp_valid, rdata, err);
    else passes++;
    take_rsp();
  endtask

  task automatic test_back_pressure();
    mem_req_ready = 1'b0;
    send_req(64'h8000_0004, 64'h1234_5678, OP_LW, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_req_ready = 1'b1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_wdata !== 64'h1234_5678_0000_0000 ||
          mem_wmask !== 8'hF0 || mem_we !== 1'b1 || req_ready !== 1'b0)
        $display("FAIL bp_req_hold_%0d: got valid=%b addr=%h wdata=%h wmask=%h we=%b req_ready=%b expected 1 80000000 1234567800000000 f0 1 0",
                 i, mem_req_valid, mem_addr, mem_wdata, mem_wmask, mem_we, req_ready);
      else passes++;
      tick();
    end
    checks++;
    if (mem_req_valid !== 1'b0) $display("FAIL bp_handshake: got %b expected 0", mem_req_valid);
    else passes++;
    mem_respond(WORD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rdata !== 64'h0 || err !== 1'b0 || req_ready !== 1'b0)
        $display("FAIL bp_rsp_hold_%0d: got valid=%b rdata=%h err=%b req_ready=%b expected 1 0 0 0", i, rsp_valid, rdata, err, req_ready);
      else passes++;
      tick();
    end
    take_rsp();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_release: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    send_req(64'h8000_0005, 64'h0, OP_LBU, 1'b0);
    tick();
    mem_respond(WORD, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'h33)
      $display("FAIL b2b_first: got valid=%b rdata=%h expected 1 33", rsp_valid, rdata);
    else passes++;
    // Request presented while the response is being taken must wait one cycle.
    set_req(64'h8000_0004, 64'h0, OP_LWU, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0)
      $display("FAIL b2b_no_early_accept: got req_ready=%b mem_req_valid=%b expected 1 0", req_ready, mem_req_valid);
    else passes++;
    tick();
    req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL b2b_accept: got mem_req_valid=%b req_ready=%b expected 1 0", mem_req_valid, req_ready);
    else passes++;
    tick();
    mem_respond(WORD, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata !== 64'h1122_3344)
      $display("FAIL b2b_second: got valid=%b rdata=%h expected 1 11223344", rsp_valid, rdata);
    else passes++;
    take_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting lsu_ctrl directed tests");
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_load_extend();
    test_none_and_bus_err();
    test_timeout();
    test_reset_in_wait();
    test_back_pressure();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
